hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage CPU.
- Drives stall/flush of PC, IF/ID and ID/EX registers and generates the 2-bit forwarding selects that ID/EX latches alongside the instruction.
- Detects load-use hazards and holds fetch/decode for a configurable number of bubble cycles.
- Squashes wrong-path instructions on taken branch/jump resolved in EX; parks the pipeline on halt.

---
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use bubbles, branch squash, halt parking, forwarding selects.
// Optional `HAZARD_PERF_EN adds stall_cnt/flush_cnt performance counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned REG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_rw,
  input  logic             ex_mtr,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             mem_rw,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             br_taken,
  input  logic             halt_req,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic [1:0]       forward1,
  output logic [1:0]       forward2,
  output logic             halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, LU_STALL, HALT} state_e;

  localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hit_rs, hit_rt, lu;

  // EX result beats MEM result; register 0 and unused operands never forward.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] src);
    if (!used || src == '0)                fwd_sel = 2'b00;
    else if (ex_rw && ex_dst == src)       fwd_sel = 2'b01;
    else if (mem_rw && mem_dst == src)     fwd_sel = 2'b10;
    else                                   fwd_sel = 2'b00;
  endfunction

  assign hit_rs = id_use_rs && (id_rs != '0) && (id_rs == ex_dst);
  assign hit_rt = id_use_rt && (id_rt != '0) && (id_rt == ex_dst);
  assign lu     = ex_rw && ex_mtr && (hit_rs || hit_rt);

  always_comb begin
    // NOTE: every output and next-state signal gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_stall = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    forward1   = fwd_sel(id_use_rs, id_rs);
    forward2   = fwd_sel(id_use_rt, id_rt);

    unique case (state_q)
      RUN: begin
        if (br_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (halt_req) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          state_d    = HALT;
        end else if (lu) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          if (LOAD_LAT > 1) begin
            cnt_d   = LU_INIT;
            state_d = LU_STALL;
          end
        end
      end
      LU_STALL: begin
        if (br_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          cnt_d      = 3'd0;
          state_d    = RUN;
        end else begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          cnt_d      = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = RUN;
        end
      end
      HALT: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_stall = 1'b1;
        halted     = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase

    // Reset squashes both pipeline registers and overrides everything else.
    if (rst) begin
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      idex_stall = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      forward1   = 2'b00;
      forward2   = 2'b00;
      halted     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && state_q != HALT)  stall_cnt_d = stall_cnt_q + 32'd1;
    if (br_taken && state_q != HALT)  flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three instances (LOAD_LAT 1, 3, 4) share stimulus;
// expected outputs go through a scoreboard queue and are compared at the falling edge.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs, id_rt;
    logic       use_rs, use_rt, ex_rw, ex_mtr;
    logic [4:0] ex_dst;
    logic       mem_rw;
    logic [4:0] mem_dst;
    logic       br, halt;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [9:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    int         dut;
    logic [9:0] exp;
  } sb_t;

  logic       clk;
  logic       rst, id_use_rs, id_use_rt, ex_rw, ex_mtr, mem_rw, br_taken, halt_req;
  logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
  wire  [9:0] o1, o3, o4;

  int checks = 0;
  int errors = 0;
  sb_t sb_q[$];

`ifdef HAZARD_PERF_EN
  wire [31:0] sc1, sc3, sc4, fc1, fc3, fc4;
`endif

  hazard_ctrl #(.LOAD_LAT(1), .REG_W(5)) u1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rw(ex_rw), .ex_mtr(ex_mtr), .ex_dst(ex_dst), .mem_rw(mem_rw), .mem_dst(mem_dst),
    .br_taken(br_taken), .halt_req(halt_req),
    .pc_stall(o1[9]), .ifid_stall(o1[8]), .ifid_flush(o1[7]), .idex_stall(o1[6]), .idex_flush(o1[5]),
    .forward1(o1[4:3]), .forward2(o1[2:1]), .halted(o1[0])
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
  );

  hazard_ctrl #(.LOAD_LAT(3), .REG_W(5)) u3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rw(ex_rw), .ex_mtr(ex_mtr), .ex_dst(ex_dst), .mem_rw(mem_rw), .mem_dst(mem_dst),
    .br_taken(br_taken), .halt_req(halt_req),
    .pc_stall(o3[9]), .ifid_stall(o3[8]), .ifid_flush(o3[7]), .idex_stall(o3[6]), .idex_flush(o3[5]),
    .forward1(o3[4:3]), .forward2(o3[2:1]), .halted(o3[0])
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
  );

  hazard_ctrl #(.LOAD_LAT(4), .REG_W(5)) u4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rw(ex_rw), .ex_mtr(ex_mtr), .ex_dst(ex_dst), .mem_rw(mem_rw), .mem_dst(mem_dst),
    .br_taken(br_taken), .halt_req(halt_req),
    .pc_stall(o4[9]), .ifid_stall(o4[8]), .ifid_flush(o4[7]), .idex_stall(o4[6]), .idex_flush(o4[5]),
    .forward1(o4[4:3]), .forward2(o4[2:1]), .halted(o4[0])
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc4), .flush_cnt(fc4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output record: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, fw1, fw2, halted}
  function automatic logic [9:0] mk(input logic ps, input logic is, input logic ifl, input logic xs,
                                    input logic xf, input logic [1:0] f1, input logic [1:0] f2,
                                    input logic h);
    return {ps, is, ifl, xs, xf, f1, f2, h};
  endfunction

  function automatic in_t fwd_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                 input logic urt, input logic exrw, input logic exmtr,
                                 input logic [4:0] exdst, input logic memrw, input logic [4:0] memdst);
    in_t v;
    v = '0;
    v.id_rs = rs;  v.id_rt = rt;  v.use_rs = urs;  v.use_rt = urt;
    v.ex_rw = exrw; v.ex_mtr = exmtr; v.ex_dst = exdst;
    v.mem_rw = memrw; v.mem_dst = memdst;
    return v;
  endfunction

  function automatic logic [9:0] got(input int d);
    case (d)
      1:       return o1;
      3:       return o3;
      default: return o4;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    rst = v.rst; id_rs = v.id_rs; id_rt = v.id_rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
    ex_rw = v.ex_rw; ex_mtr = v.ex_mtr; ex_dst = v.ex_dst; mem_rw = v.mem_rw; mem_dst = v.mem_dst;
    br_taken = v.br; halt_req = v.halt;
  endtask

  // Drive one cycle, queue expectations per instance, compare at the falling edge.
  task automatic step(input string name, input in_t v, input logic [9:0] e1,
                      input logic [9:0] e3, input logic [9:0] e4);
    sb_t s;
    drive(v);
    sb_q.push_back('{{name, "/L1"}, 1, e1});
    sb_q.push_back('{{name, "/L3"}, 3, e3});
    sb_q.push_back('{{name, "/L4"}, 4, e4});
    @(negedge clk);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      check(s.name, 32'(got(s.dut)), 32'(s.exp));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step_all(input string name, input in_t v, input logic [9:0] e);
    step(name, v, e, e, e);
  endtask

  logic [9:0] zero_o, flush_o, stall_o, halt_o;
  in_t        idle, rst_in, lu_v, bub_v, v;
  vec_t       vecs[10];

  initial begin
    zero_o  = '0;
    flush_o = mk(0, 0, 1, 0, 1, 2'b00, 2'b00, 0);
    stall_o = mk(1, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    halt_o  = mk(1, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    idle    = '0;
    rst_in  = '0;
    rst_in.rst = 1'b1;
    lu_v    = fwd_in(0, 8, 0, 1, 1, 1, 8, 0, 0);
    bub_v   = fwd_in(0, 8, 0, 1, 0, 0, 0, 1, 8);

    vecs[0] = '{"fwd_ex",          fwd_in(5, 0, 1, 0, 1, 0, 5, 1, 5), mk(0,0,0,0,0,2'b01,2'b00,0)};
    vecs[1] = '{"fwd_mem",         fwd_in(5, 0, 1, 0, 0, 0, 5, 1, 5), mk(0,0,0,0,0,2'b10,2'b00,0)};
    vecs[2] = '{"fwd_r0",          fwd_in(0, 0, 1, 1, 1, 0, 0, 1, 0), zero_o};
    vecs[3] = '{"fwd_rt_mem",      fwd_in(0, 7, 0, 1, 0, 0, 0, 1, 7), mk(0,0,0,0,0,2'b00,2'b10,0)};
    vecs[4] = '{"fwd_both",        fwd_in(3, 4, 1, 1, 1, 0, 3, 1, 4), mk(0,0,0,0,0,2'b01,2'b10,0)};
    vecs[5] = '{"fwd_unused",      fwd_in(5, 5, 0, 0, 1, 0, 5, 1, 5), zero_o};
    vecs[6] = '{"mtr_without_rw",  fwd_in(6, 0, 1, 0, 0, 1, 6, 0, 0), zero_o};
    vecs[7] = '{"load_to_r0",      fwd_in(0, 0, 1, 1, 1, 1, 0, 0, 0), zero_o};
    vecs[8] = '{"ex_over_mem_rt",  fwd_in(0, 9, 0, 1, 1, 0, 9, 1, 9), mk(0,0,0,0,0,2'b00,2'b01,0)};
    vecs[9] = '{"ex_miss_mem_hit", fwd_in(2, 0, 1, 0, 1, 0, 3, 1, 2), mk(0,0,0,0,0,2'b10,2'b00,0)};

    step_all("reset0", rst_in, flush_o);
    step_all("reset1", rst_in, flush_o);
    step_all("idle",   idle,   zero_o);

    for (int i = 0; i < 10; i++) step_all(vecs[i].name, vecs[i].in, vecs[i].exp);

    // Load-use: bubbles last exactly LOAD_LAT cycles in each instance.
    step_all("lu_c0", lu_v, mk(1,1,0,0,1,2'b00,2'b01,0));
    step("lu_c1", bub_v, mk(0,0,0,0,0,2'b00,2'b10,0),
         mk(1,1,0,0,1,2'b00,2'b10,0), mk(1,1,0,0,1,2'b00,2'b10,0));
    step("lu_c2", idle, zero_o, stall_o, stall_o);
    step("lu_c3", idle, zero_o, zero_o,  stall_o);
    step_all("lu_c4", idle, zero_o);

    // Branch beats a coincident load-use and no bubble follows.
    v = lu_v; v.br = 1'b1;
    step_all("br_over_lu", v, mk(0,0,1,0,1,2'b00,2'b01,0));
    step_all("br_over_lu_after", idle, zero_o);

    // Branch while a multi-cycle bubble is in progress.
    step_all("lu_then_br_c0", lu_v, mk(1,1,0,0,1,2'b00,2'b01,0));
    v = bub_v; v.br = 1'b1;
    step_all("br_in_lu_stall", v, mk(0,0,1,0,1,2'b00,2'b10,0));
    step_all("br_in_lu_after", idle, zero_o);

    // Branch beats halt.
    v = idle; v.br = 1'b1; v.halt = 1'b1;
    step_all("br_over_halt", v, flush_o);
    step_all("br_over_halt_after", idle, zero_o);

    // Halt parks the pipeline; branch and further halts are ignored until reset.
    v = idle; v.halt = 1'b1;
    step_all("halt_req", v, stall_o);
    for (int i = 0; i < 10; i++) begin
      v = idle;
      v.br   = (i == 4);
      v.halt = (i == 7);
      step_all($sformatf("halted_%0d", i), v, halt_o);
    end
    step_all("halt_rst", rst_in, flush_o);
    step_all("halt_rst_after", idle, zero_o);

    // Reset mid-stall: two bubbles in, then reset leaves no residue.
    step_all("rlu_c0", lu_v, mk(1,1,0,0,1,2'b00,2'b01,0));
    step("rlu_c1", bub_v, mk(0,0,0,0,0,2'b00,2'b10,0),
         mk(1,1,0,0,1,2'b00,2'b10,0), mk(1,1,0,0,1,2'b00,2'b10,0));
    step_all("rlu_rst", rst_in, flush_o);
    step_all("rlu_after0", idle, zero_o);
    step_all("rlu_after1", idle, zero_o);

`ifdef HAZARD_PERF_EN
    check("perf_stall_after_rst", sc4, 32'd0);
    check("perf_flush_after_rst", fc4, 32'd0);
    step_all("perf_lu_c0", lu_v, mk(1,1,0,0,1,2'b00,2'b01,0));
    step("perf_lu_c1", idle, zero_o, stall_o, stall_o);
    step("perf_lu_c2", idle, zero_o, stall_o, stall_o);
    step("perf_lu_c3", idle, zero_o, zero_o,  stall_o);
    step_all("perf_lu_c4", idle, zero_o);
    check("perf_stall_l1", sc1, 32'd1);
    check("perf_stall_l3", sc3, 32'd3);
    check("perf_stall_l4", sc4, 32'd4);
    v = idle; v.br = 1'b1;
    step_all("perf_br", v, flush_o);
    check("perf_flush_l4", fc4, 32'd1);
    v = idle; v.halt = 1'b1;
    step_all("perf_halt", v, stall_o);
    for (int i = 0; i < 3; i++) begin
      v = idle; v.br = 1'b1;
      step_all($sformatf("perf_halted_%0d", i), v, halt_o);
    end
    check("perf_stall_excl_halt", sc4, 32'd5);
    check("perf_flush_excl_halt", fc4, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
